// File: rtl/player_move_ctrl_if.sv
// Request/acknowledge and position bundle between the two player inputs and player_move_ctrl.
interface player_move_ctrl_if;
    logic       reqA;
    logic       reqB;
    logic [1:0] dirA;
    logic [1:0] dirB;
    logic [3:0] curAh;
    logic [3:0] curAv;
    logic [3:0] curBh;
    logic [3:0] curBv;
    logic       ackA;
    logic       ackB;
    logic       okA;
    logic       okB;
    logic       busy;

    modport master (
        output reqA, reqB, dirA, dirB,
        input  curAh, curAv, curBh, curBv, ackA, ackB, okA, okB, busy
    );

    modport slave (
        input  reqA, reqB, dirA, dirB,
        output curAh, curAv, curBh, curBv, ackA, ackB, okA, okB, busy
    );
endinterface

// File: rtl/player_move_ctrl.sv
// Two-player tile movement arbiter: round-robin grant, one-cycle legality check, per-move cooldown.
// Optional macro WATER_BLOCK_EN makes water columns (h mod 3 == 0) impassable.
module player_move_ctrl #(
    parameter int STEP_CYCLES = 10_000_000,
    parameter int A_H0        = 1,
    parameter int A_V0        = 1,
    parameter int B_H0        = 8,
    parameter int B_V0        = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    player_move_ctrl_if.slave bus
);
    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_CHECK  = 2'd1;
    localparam logic [1:0]  S_COOL   = 2'd2;
    localparam logic [23:0] CNT_LOAD = 24'(STEP_CYCLES - 1);
    localparam logic [3:0]  A_H0_L   = 4'(A_H0);
    localparam logic [3:0]  A_V0_L   = 4'(A_V0);
    localparam logic [3:0]  B_H0_L   = 4'(B_H0);
    localparam logic [3:0]  B_V0_L   = 4'(B_V0);

    logic [1:0]  state_q, state_d;
    logic        pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic [1:0]  dir_a_q, dir_a_d, dir_b_q, dir_b_d;
    logic        grant_b_q, grant_b_d;
    logic        last_b_q, last_b_d;
    logic [3:0]  a_h_q, a_h_d, a_v_q, a_v_d, b_h_q, b_h_d, b_v_q, b_v_d;
    logic [23:0] cnt_q, cnt_d;
    logic        ack_a_q, ack_a_d, ok_a_q, ok_a_d;
    logic        ack_b_q, ack_b_d, ok_b_q, ok_b_d;
    logic        busy_q, busy_d;

    logic [3:0]        sel_h_s, sel_v_s, oth_h_s, oth_v_s, tgt_h_u_s, tgt_v_u_s;
    logic [1:0]        sel_dir_s;
    logic signed [4:0] tgt_h_s, tgt_v_s;
    logic              in_bounds_s, wall_s, occupied_s, water_blk_s, legal_s;
    logic              clear_a_s, clear_b_s;

    assign sel_h_s   = grant_b_q ? b_h_q : a_h_q;
    assign sel_v_s   = grant_b_q ? b_v_q : a_v_q;
    assign oth_h_s   = grant_b_q ? a_h_q : b_h_q;
    assign oth_v_s   = grant_b_q ? a_v_q : b_v_q;
    assign sel_dir_s = grant_b_q ? dir_b_q : dir_a_q;

    // Target tile of the granted player, signed so that stepping off the top/left edge goes negative.
    always_comb begin
        tgt_h_s = $signed({1'b0, sel_h_s});
        tgt_v_s = $signed({1'b0, sel_v_s});
        case (sel_dir_s)
            2'b00:   tgt_v_s = $signed({1'b0, sel_v_s}) - 5'sd1;
            2'b01:   tgt_v_s = $signed({1'b0, sel_v_s}) + 5'sd1;
            2'b10:   tgt_h_s = $signed({1'b0, sel_h_s}) - 5'sd1;
            2'b11:   tgt_h_s = $signed({1'b0, sel_h_s}) + 5'sd1;
            default: tgt_h_s = $signed({1'b0, sel_h_s});
        endcase
    end

    assign tgt_h_u_s   = tgt_h_s[3:0];
    assign tgt_v_u_s   = tgt_v_s[3:0];
    assign in_bounds_s = (tgt_h_s >= 5'sd0) && (tgt_h_s <= 5'sd9) &&
                         (tgt_v_s >= 5'sd0) && (tgt_v_s <= 5'sd5);
    assign wall_s      = ((tgt_h_u_s % 4'd3) != 4'd0) && (tgt_v_u_s[1:0] == 2'b00);
    assign occupied_s  = (tgt_h_u_s == oth_h_s) && (tgt_v_u_s == oth_v_s);
`ifdef WATER_BLOCK_EN
    assign water_blk_s = (tgt_h_u_s % 4'd3) == 4'd0;
`else
    assign water_blk_s = 1'b0;
`endif
    assign legal_s     = in_bounds_s && !wall_s && !occupied_s && !water_blk_s;

    // A fresh request always wins over the clear issued when its previous one resolves.
    assign clear_a_s = (state_q == S_CHECK) && !grant_b_q;
    assign clear_b_s = (state_q == S_CHECK) &&  grant_b_q;
    assign pend_a_d  = bus.reqA | (pend_a_q & ~clear_a_s);
    assign pend_b_d  = bus.reqB | (pend_b_q & ~clear_b_s);
    assign dir_a_d   = bus.reqA ? bus.dirA : dir_a_q;
    assign dir_b_d   = bus.reqB ? bus.dirB : dir_b_q;

    // Arbitration, move resolution and cooldown sequencing.
    always_comb begin
        state_d   = state_q;
        grant_b_d = grant_b_q;
        last_b_d  = last_b_q;
        a_h_d     = a_h_q;
        a_v_d     = a_v_q;
        b_h_d     = b_h_q;
        b_v_d     = b_v_q;
        cnt_d     = cnt_q;
        ack_a_d   = 1'b0;
        ok_a_d    = 1'b0;
        ack_b_d   = 1'b0;
        ok_b_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_a_q || pend_b_q) begin
                    grant_b_d = pend_b_q && (!pend_a_q || !last_b_q);
                    last_b_d  = pend_b_q && (!pend_a_q || !last_b_q);
                    state_d   = S_CHECK;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_CHECK: begin
                if (grant_b_q) begin
                    ack_b_d = 1'b1;
                    ok_b_d  = legal_s;
                    b_h_d   = legal_s ? tgt_h_u_s : b_h_q;
                    b_v_d   = legal_s ? tgt_v_u_s : b_v_q;
                end else begin
                    ack_a_d = 1'b1;
                    ok_a_d  = legal_s;
                    a_h_d   = legal_s ? tgt_h_u_s : a_h_q;
                    a_v_d   = legal_s ? tgt_v_u_s : a_v_q;
                end
                state_d = legal_s ? S_COOL : S_IDLE;
                cnt_d   = legal_s ? CNT_LOAD : 24'd0;
            end
            S_COOL: begin
                if (cnt_q == 24'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q - 24'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset discards any in-flight move without an acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pend_a_q  <= 1'b0;
            pend_b_q  <= 1'b0;
            dir_a_q   <= 2'b00;
            dir_b_q   <= 2'b00;
            grant_b_q <= 1'b0;
            last_b_q  <= 1'b1;
            a_h_q     <= A_H0_L;
            a_v_q     <= A_V0_L;
            b_h_q     <= B_H0_L;
            b_v_q     <= B_V0_L;
            cnt_q     <= 24'd0;
            ack_a_q   <= 1'b0;
            ok_a_q    <= 1'b0;
            ack_b_q   <= 1'b0;
            ok_b_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_a_q  <= pend_a_d;
            pend_b_q  <= pend_b_d;
            dir_a_q   <= dir_a_d;
            dir_b_q   <= dir_b_d;
            grant_b_q <= grant_b_d;
            last_b_q  <= last_b_d;
            a_h_q     <= a_h_d;
            a_v_q     <= a_v_d;
            b_h_q     <= b_h_d;
            b_v_q     <= b_v_d;
            cnt_q     <= cnt_d;
            ack_a_q   <= ack_a_d;
            ok_a_q    <= ok_a_d;
            ack_b_q   <= ack_b_d;
            ok_b_q    <= ok_b_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.curAh = a_h_q;
    assign bus.curAv = a_v_q;
    assign bus.curBh = b_h_q;
    assign bus.curBv = b_v_q;
    assign bus.ackA  = ack_a_q;
    assign bus.okA   = ok_a_q;
    assign bus.ackB  = ack_b_q;
    assign bus.okB   = ok_b_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl with a short cooldown (STEP_CYCLES = 4) and default start tiles.
module tb_player_move_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    player_move_ctrl_if bus();

    player_move_ctrl #(.STEP_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    int   a_cyc, b_cyc, a_cnt, b_cnt, busy_cnt;
    logic a_ok, b_ok;
    logic [1:0] route [10];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.reqA = 1'b0;
        bus.reqB = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
    endtask

    // Pulse the requested players for one cycle, then watch a fixed number of cycles.
    task automatic issue(input logic ra, input logic [1:0] da, input logic rb, input logic [1:0] db,
                         input int budget);
        a_cyc = 0; b_cyc = 0; a_cnt = 0; b_cnt = 0; busy_cnt = 0; a_ok = 1'b0; b_ok = 1'b0;
        @(negedge clk);
        bus.reqA = ra; bus.dirA = da; bus.reqB = rb; bus.dirB = db;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                bus.reqA = 1'b0;
                bus.reqB = 1'b0;
            end
            if (bus.ackA) begin
                a_cnt++;
                if (a_cyc == 0) begin a_cyc = c; a_ok = bus.okA; end
            end
            if (bus.ackB) begin
                b_cnt++;
                if (b_cyc == 0) begin b_cyc = c; b_ok = bus.okB; end
            end
            if (bus.busy) busy_cnt++;
        end
    endtask

    initial begin
        bus.reqA = 1'b0; bus.reqB = 1'b0; bus.dirA = 2'b00; bus.dirB = 2'b00;
        route = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        do_reset();
        chk("rst_Ah", bus.curAh, 1); chk("rst_Av", bus.curAv, 1);
        chk("rst_Bh", bus.curBh, 8); chk("rst_Bv", bus.curBv, 5);
        chk("rst_busy", bus.busy, 0); chk("rst_ackA", bus.ackA, 0); chk("rst_ackB", bus.ackB, 0);

        // A right from (1,1): legal, latency 3, busy for check plus four cooldown cycles
        issue(1'b1, 2'b11, 1'b0, 2'b00, 10);
        chk("r1_lat", a_cyc, 3); chk("r1_ok", a_ok, 1); chk("r1_acks", a_cnt, 1);
        chk("r1_busy", busy_cnt, 5); chk("r1_Ah", bus.curAh, 2); chk("r1_Av", bus.curAv, 1);

        // A right from (2,1) onto water column 3
        issue(1'b1, 2'b11, 1'b0, 2'b00, 10);
`ifdef WATER_BLOCK_EN
        chk("water_ok", a_ok, 0); chk("water_Ah", bus.curAh, 2);
`else
        chk("water_ok", a_ok, 1); chk("water_Ah", bus.curAh, 3);
`endif

        // A up from (1,1) into the wall at (1,0): rejected, no cooldown
        do_reset();
        issue(1'b1, 2'b00, 1'b0, 2'b00, 10);
        chk("wall_lat", a_cyc, 3); chk("wall_ok", a_ok, 0); chk("wall_busy", busy_cnt, 1);
        chk("wall_Ah", bus.curAh, 1); chk("wall_Av", bus.curAv, 1);

        // B down from (8,5): off the bottom edge
        issue(1'b0, 2'b00, 1'b1, 2'b01, 10);
        chk("bnd_ok", b_ok, 0); chk("bnd_Bv", bus.curBv, 5); chk("bnd_ackA", a_cnt, 0);

        // Tie after B was last granted: A first, B after A's cooldown
        issue(1'b1, 2'b01, 1'b1, 2'b10, 16);
        chk("tie1_A_lat", a_cyc, 3); chk("tie1_A_ok", a_ok, 1);
        chk("tie1_B_lat", b_cyc, 9); chk("tie1_B_ok", b_ok, 1);
        chk("tie1_busy", busy_cnt, 10); chk("tie1_Av", bus.curAv, 2); chk("tie1_Bh", bus.curBh, 7);

        // Single A move, so A is last granted
        issue(1'b1, 2'b01, 1'b0, 2'b00, 10);
        chk("solo_ok", a_ok, 1); chk("solo_Av", bus.curAv, 3);

        // Tie after A was last granted: B first (wall at (7,4), rejected), then A to (2,3)
        issue(1'b1, 2'b11, 1'b1, 2'b00, 12);
        chk("tie2_B_lat", b_cyc, 3); chk("tie2_B_ok", b_ok, 0);
        chk("tie2_A_lat", a_cyc, 5); chk("tie2_A_ok", a_ok, 1);
        chk("tie2_Ah", bus.curAh, 2); chk("tie2_Bv", bus.curBv, 5);

`ifndef WATER_BLOCK_EN
        // Walk B from (8,5) to (2,1) through water column 3, then try to collide both ways
        do_reset();
        for (int i = 0; i < 10; i++) begin
            issue(1'b0, 2'b00, 1'b1, route[i], 10);
            chk("route_ok", b_ok, 1);
        end
        chk("route_Bh", bus.curBh, 2); chk("route_Bv", bus.curBv, 1);
        issue(1'b1, 2'b11, 1'b0, 2'b00, 10);
        chk("occA_ok", a_ok, 0); chk("occA_Ah", bus.curAh, 1);
        issue(1'b0, 2'b00, 1'b1, 2'b10, 10);
        chk("occB_ok", b_ok, 0); chk("occB_Bh", bus.curBh, 2);
`endif

        // Reset during cooldown after A moved to (2,1)
        do_reset();
        issue(1'b1, 2'b11, 1'b0, 2'b00, 4);
        chk("rcd_lat", a_cyc, 3); chk("rcd_busy_pre", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rcd_Ah", bus.curAh, 1); chk("rcd_busy", bus.busy, 0); chk("rcd_ack", bus.ackA, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 2'b00, 1'b0, 2'b00, 8);
        chk("rcd_noack", a_cnt, 0); chk("rcd_idle", busy_cnt, 0);

        // Reset while the request is being checked
        issue(1'b1, 2'b11, 1'b0, 2'b00, 2);
        chk("rck_busy_pre", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rck_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 2'b00, 1'b0, 2'b00, 8);
        chk("rck_noack", a_cnt, 0); chk("rck_Ah", bus.curAh, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
